// File: rtl/wb_stage_pkg.sv
// Shared constants for the write-back stage: control bus bit positions and
// the load-width encodings carried down the pipeline from decode.
package wb_stage_pkg;

  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian sub-word extraction for loads (byte 0 lives in the top bits),
// with sign/zero extension and alignment checking.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            load_type,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = mem_data[31:24];
    case (offset)
      2'd1:    byte_val = mem_data[23:16];
      2'd2:    byte_val = mem_data[15:8];
      2'd3:    byte_val = mem_data[7:0];
      default: byte_val = mem_data[31:24];
    endcase
    half_val = offset[1] ? mem_data[15:0] : mem_data[31:16];

    // Unknown encodings behave as a full-word load, alignment rule included.
    data       = mem_data;
    misaligned = (offset != 2'b00);
    case (load_type)
      LT_LH: begin
        data       = {{(DATA_WIDTH-16){half_val[15]}}, half_val};
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = {{(DATA_WIDTH-16){1'b0}}, half_val};
        misaligned = offset[0];
      end
      LT_LB: begin
        data       = {{(DATA_WIDTH-8){byte_val[7]}}, byte_val};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        data       = {{(DATA_WIDTH-8){1'b0}}, byte_val};
        misaligned = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB pipeline register, load data formatting,
// register-bank write port, misaligned-load reporting and retirement count.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int WB_BUS_WIDTH  = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_in,
  input  logic                     stall_in,
  input  logic                     flush_in,
  input  logic [WB_BUS_WIDTH-1:0]  wb_bus_in,
  input  logic [2:0]               load_type_in,
  input  logic [DATA_WIDTH-1:0]    alu_result_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [REG_ADDR_BITS-1:0] add_reg_w_in,
  output logic                     write_w,
  output logic [REG_ADDR_BITS-1:0] add_reg_w_out,
  output logic [DATA_WIDTH-1:0]    reg_w_data_out,
  output logic                     misaligned_err,
  output logic [CNT_WIDTH-1:0]     retired_cnt
);

  logic                     valid_q;
  logic [WB_BUS_WIDTH-1:0]  wb_bus_q;
  logic [2:0]               load_type_q;
  logic [DATA_WIDTH-1:0]    alu_result_q;
  logic [DATA_WIDTH-1:0]    mem_data_q;
  logic [REG_ADDR_BITS-1:0] add_reg_w_q;
  logic                     err_reported;

  logic [DATA_WIDTH-1:0]    load_data;
  logic                     align_fault;
  logic                     misaligned_now;
  logic                     reg_write;
  logic                     mem_to_reg;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .load_type  (load_type_q),
    .offset     (alu_result_q[1:0]),
    .mem_data   (mem_data_q),
    .data       (load_data),
    .misaligned (align_fault)
  );

  assign reg_write      = wb_bus_q[WB_REG_WRITE];
  assign mem_to_reg     = wb_bus_q[WB_MEM_TO_REG];
  assign misaligned_now = valid_q & mem_to_reg & reg_write & align_fault;
  assign write_w        = valid_q & reg_write & (add_reg_w_q != '0) & ~misaligned_now;
  assign add_reg_w_out  = add_reg_w_q;
  assign reg_w_data_out = mem_to_reg ? load_data : alu_result_q;

  // err_reported remembers that a stalled misaligned load already pulsed,
  // and is cleared whenever the register takes on new content.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q        <= 1'b0;
      wb_bus_q       <= '0;
      load_type_q    <= '0;
      alu_result_q   <= '0;
      mem_data_q     <= '0;
      add_reg_w_q    <= '0;
      err_reported   <= 1'b0;
      misaligned_err <= 1'b0;
      retired_cnt    <= '0;
    end else begin
      if (flush_in) begin
        valid_q  <= 1'b0;
        wb_bus_q <= '0;
      end else if (!stall_in) begin
        valid_q      <= valid_in;
        wb_bus_q     <= wb_bus_in;
        load_type_q  <= load_type_in;
        alu_result_q <= alu_result_in;
        mem_data_q   <= mem_data_in;
        add_reg_w_q  <= add_reg_w_in;
      end

      if (valid_q && !stall_in)
        retired_cnt <= retired_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

      misaligned_err <= misaligned_now & ~err_reported;
      if (flush_in || !stall_in)
        err_reported <= 1'b0;
      else if (misaligned_now)
        err_reported <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model
// of the write-back rules.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in, stall_in, flush_in;
  logic [1:0]  wb_bus_in;
  logic [2:0]  load_type_in;
  logic [31:0] alu_result_in, mem_data_in;
  logic [4:0]  add_reg_w_in;
  logic        write_w;
  logic [4:0]  add_reg_w_out;
  logic [31:0] reg_w_data_out;
  logic        misaligned_err;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: the instruction currently sitting in write-back.
  bit          m_valid;
  int unsigned m_wb, m_lt, m_alu, m_mem, m_rd;
  int unsigned m_cnt;
  bit          m_err, m_reported;

  wb_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_in       (valid_in),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .wb_bus_in      (wb_bus_in),
    .load_type_in   (load_type_in),
    .alu_result_in  (alu_result_in),
    .mem_data_in    (mem_data_in),
    .add_reg_w_in   (add_reg_w_in),
    .write_w        (write_w),
    .add_reg_w_out  (add_reg_w_out),
    .reg_w_data_out (reg_w_data_out),
    .misaligned_err (misaligned_err),
    .retired_cnt    (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int unsigned modelLoad(int unsigned lt, int unsigned alu, int unsigned mem);
    int unsigned off = alu % 4;
    int unsigned h = (off >= 2) ? (mem % 65536) : (mem / 65536);
    int unsigned b = (mem >> (8 * (3 - off))) % 256;
    case (lt)
      1: return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      2: return h;
      3: return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      4: return b;
      default: return mem;
    endcase
  endfunction

  function automatic bit modelMisaligned();
    int unsigned off = m_alu % 4;
    bit bad;
    if (m_lt == 1 || m_lt == 2) bad = (off % 2) == 1;
    else if (m_lt == 3 || m_lt == 4) bad = 0;
    else bad = (off != 0);
    return m_valid && (m_wb == 3) && bad;
  endfunction

  task automatic modelReset();
    m_valid = 0; m_wb = 0; m_lt = 0; m_alu = 0; m_mem = 0; m_rd = 0;
    m_cnt = 0; m_err = 0; m_reported = 0;
  endtask

  task automatic checkAll();
    bit          mis = modelMisaligned();
    bit          exp_w = m_valid && (m_wb % 2 == 1) && (m_rd != 0) && !mis;
    int unsigned exp_d = (m_wb >= 2) ? modelLoad(m_lt, m_alu, m_mem) : m_alu;
    checkOutput("write_w", {31'd0, write_w}, {31'd0, exp_w});
    checkOutput("add_reg_w_out", {27'd0, add_reg_w_out}, m_rd);
    checkOutput("reg_w_data_out", reg_w_data_out, exp_d);
    checkOutput("misaligned_err", {31'd0, misaligned_err}, {31'd0, m_err});
    checkOutput("retired_cnt", retired_cnt, m_cnt);
  endtask

  // Drive one cycle of MEM-side inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input bit v, input bit s, input bit f, input int unsigned wb,
                               input int unsigned lt, input int unsigned alu,
                               input int unsigned mem, input int unsigned rd);
    bit mis_old;
    valid_in = v; stall_in = s; flush_in = f;
    wb_bus_in = 2'(wb); load_type_in = 3'(lt); alu_result_in = alu;
    mem_data_in = mem; add_reg_w_in = 5'(rd);
    @(posedge clk);
    mis_old = modelMisaligned();
    if (m_valid && !s) m_cnt++;
    m_err = mis_old && !m_reported;
    if (f || !s) m_reported = 0;
    else if (mis_old) m_reported = 1;
    if (f) begin
      m_valid = 0; m_wb = 0;
    end else if (!s) begin
      m_valid = v; m_wb = wb % 4; m_lt = lt % 8; m_alu = alu; m_mem = mem; m_rd = rd % 32;
    end
    #1;
    checkAll();
  endtask

  initial begin
    int pulses;
    int unsigned cnt_before;
    reset_n = 1'b0;
    valid_in = 0; stall_in = 0; flush_in = 0; wb_bus_in = 0; load_type_in = 0;
    alu_result_in = 0; mem_data_in = 0; add_reg_w_in = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkAll();
    reset_n = 1'b1;

    applyStimulus(1, 0, 0, 1, 0, 32'h0000_1234, 32'h0, 8);
    checkOutput("alu_write", {31'd0, write_w}, 32'd1);
    checkOutput("alu_data", reg_w_data_out, 32'h0000_1234);

    applyStimulus(1, 0, 0, 3, 3, 32'h101, 32'h80FF_7F01, 9);
    checkOutput("lb_off1", reg_w_data_out, 32'hFFFF_FFFF);
    checkOutput("cnt_after_alu", retired_cnt, 32'd1);
    applyStimulus(1, 0, 0, 3, 4, 32'h100, 32'h80FF_7F01, 9);
    checkOutput("lbu_off0", reg_w_data_out, 32'h0000_0080);
    applyStimulus(1, 0, 0, 3, 1, 32'h102, 32'h80FF_7F01, 9);
    checkOutput("lh_off2", reg_w_data_out, 32'h0000_7F01);
    applyStimulus(1, 0, 0, 3, 2, 32'h100, 32'h80FF_7F01, 9);
    checkOutput("lhu_off0", reg_w_data_out, 32'h0000_80FF);

    applyStimulus(1, 0, 0, 1, 0, 32'h55, 32'h0, 0);
    checkOutput("zero_reg_write", {31'd0, write_w}, 32'd0);

    pulses = 0;
    applyStimulus(1, 0, 0, 3, 0, 32'h102, 32'hDEAD_BEEF, 5);
    checkOutput("mis_write", {31'd0, write_w}, 32'd0);
    cnt_before = retired_cnt;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 32'h0, 32'h0, 7);
      checkOutput("mis_stall_write", {31'd0, write_w}, 32'd0);
      checkOutput("mis_stall_cnt", retired_cnt, cnt_before);
      if (misaligned_err) pulses++;
    end
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    if (misaligned_err) pulses++;
    checkOutput("mis_pulses", pulses, 32'd1);
    checkOutput("mis_release_cnt", retired_cnt, cnt_before + 1);

    applyStimulus(1, 0, 0, 1, 0, 32'h77, 32'h0, 4);
    cnt_before = retired_cnt;
    applyStimulus(1, 1, 1, 1, 0, 32'h88, 32'h0, 6);
    checkOutput("flush_stall_write", {31'd0, write_w}, 32'd0);
    checkOutput("flush_stall_cnt", retired_cnt, cnt_before);

    for (int i = 0; i < 400; i++) begin
      int unsigned rd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 7), $urandom, $urandom, rd);
    end

    applyStimulus(1, 1, 0, 1, 0, 32'hCAFE, 32'h0, 3);
    applyStimulus(1, 0, 0, 1, 0, 32'hCAFE, 32'h0, 3);
    #2;
    checkOutput("pre_reset_write", {31'd0, write_w}, 32'd1);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    stall_in = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("post_reset_write", {31'd0, write_w}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
